debounced_switches_to_leds: RTL and testbench

DEBOUNCED_SWITCHES_TO_LEDS -- requirements
Module: debounced_switches_to_leds

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/debounce_filter.sv | 61 ++++++
 rtl/debounced_switches_to_leds.sv | 64 ++++++
 tb/tb_debounced_switches_to_leds.sv | 118 +++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared defaults and mode encodings for the switch debouncer and its LED driver.
// Also holds the parameter-legality helpers used at elaboration.
package debounce_pkg;

  localparam int DEFAULT_NUM_CH         = 4;
  localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;
  localparam int MAX_NUM_CH             = 8;
  localparam int MIN_DEBOUNCE_LIMIT     = 2;
  localparam int MAX_DEBOUNCE_LIMIT     = 1 << 20;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_TOGGLE = 1'b1
  } led_mode_e;

  function automatic bit num_ch_legal(input int num_ch);
    return (num_ch >= 1) && (num_ch <= MAX_NUM_CH);
  endfunction

  function automatic bit limit_legal(input int limit);
    return (limit >= MIN_DEBOUNCE_LIMIT) && (limit <= MAX_DEBOUNCE_LIMIT);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Single-channel debouncer: 2-flop synchroniser, persistence counter, stable state
// and a registered pulse on each accepted 1->0 transition.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic switch_raw,
  output logic stable,
  output logic fall_pulse
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             meta_r;
  logic             sync_r;
  logic             stable_r;
  logic             fall_r;
  logic [CNT_W-1:0] cnt_r;
  logic             stable_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Next count/state: any agreement clears, acceptance clears in the same cycle
  always_comb begin
    stable_nxt_s = stable_r;
    cnt_nxt_s    = {CNT_W{1'b0}};
    if (sync_r == stable_r) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_MAX) begin
      stable_nxt_s = sync_r;
      cnt_nxt_s    = {CNT_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Synchroniser, filter state and release-edge register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r   <= 1'b0;
      sync_r   <= 1'b0;
      stable_r <= 1'b0;
      fall_r   <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      meta_r   <= switch_raw;
      sync_r   <= meta_r;
      stable_r <= stable_nxt_s;
      fall_r   <= stable_r & ~stable_nxt_s;
      cnt_r    <= cnt_nxt_s;
    end
  end

  assign stable     = stable_r;
  assign fall_pulse = fall_r;

endmodule

// File: rtl/debounced_switches_to_leds.sv
// Top level: NUM_CH independent debounce filters feeding registered LED drive,
// either following the debounced switch or toggling on each debounced release.
module debounced_switches_to_leds
  import debounce_pkg::*;
#(
  parameter int NUM_CH         = DEFAULT_NUM_CH,
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int TOGGLE_MODE    = 0
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_LED,
  output logic [NUM_CH-1:0] o_Release
);

  localparam bit IS_TOGGLE = (TOGGLE_MODE == int'(MODE_TOGGLE));

  if (!num_ch_legal(NUM_CH)) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..8");
  end
  if (!limit_legal(DEBOUNCE_LIMIT)) begin : g_bad_limit
    $error("DEBOUNCE_LIMIT must be in 2..2^20");
  end
  if ((TOGGLE_MODE != int'(MODE_DIRECT)) && (TOGGLE_MODE != int'(MODE_TOGGLE))) begin : g_bad_mode
    $error("TOGGLE_MODE must be 0 or 1");
  end

  logic [NUM_CH-1:0] stable_s;
  logic [NUM_CH-1:0] fall_s;
  logic [NUM_CH-1:0] led_r;
  logic [NUM_CH-1:0] release_r;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_filter #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_filter (
      .clk       (i_Clk),
      .rst       (i_Rst),
      .switch_raw(i_Switch[ch]),
      .stable    (stable_s[ch]),
      .fall_pulse(fall_s[ch])
    );
  end

  // LED drive and release pulse, both one register after the filter outputs
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      led_r     <= {NUM_CH{1'b0}};
      release_r <= {NUM_CH{1'b0}};
    end else begin
      release_r <= fall_s;
      if (IS_TOGGLE) begin
        led_r <= led_r ^ fall_s;
      end else begin
        led_r <= stable_s;
      end
    end
  end

  assign o_LED     = led_r;
  assign o_Release = release_r;

endmodule

// File: tb/tb_debounced_switches_to_leds.sv
// Directed bench for debounced_switches_to_leds with DEBOUNCE_LIMIT=4, NUM_CH=4;
// one direct-mode and one toggle-mode instance share clock, reset and switches.
module tb_debounced_switches_to_leds;

  typedef struct {
    logic       rst;
    logic [3:0] sw;
    logic [3:0] led;
    logic [3:0] rel;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] led_d, rel_d, led_t, rel_t;
  vec_t       vecs[$];
  int         total  = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  debounced_switches_to_leds #(.NUM_CH(4), .DEBOUNCE_LIMIT(4), .TOGGLE_MODE(0)) dut_d (
    .i_Clk(clk), .i_Rst(rst), .i_Switch(sw), .o_LED(led_d), .o_Release(rel_d)
  );

  debounced_switches_to_leds #(.NUM_CH(4), .DEBOUNCE_LIMIT(4), .TOGGLE_MODE(1)) dut_t (
    .i_Clk(clk), .i_Rst(rst), .i_Switch(sw), .o_LED(led_t), .o_Release(rel_t)
  );

  task automatic add(input logic r, input logic [3:0] s, input logic [3:0] l, input logic [3:0] e);
    vecs.push_back('{r, s, l, e});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
    else passed++;
  endtask

  initial begin
    logic [7:0] bounce;
    bounce = 8'b1110_1110;
    rst = 1'b1;
    sw  = 4'b1111;

    // Reset held 3 cycles with all switches pressed, then released from reset
    for (int i = 0; i < 3; i++) add(1'b1, 4'hF, 4'h0, 4'h0);
    for (int i = 1; i <= 8; i++) add(1'b0, 4'hF, (i >= 7) ? 4'hF : 4'h0, 4'h0);
    // Reset while LEDs lit: no release pulse
    for (int i = 0; i < 2; i++) add(1'b1, 4'h0, 4'h0, 4'h0);
    // Bounce on channel 0 never accepted
    for (int k = 0; k < 8; k++) add(1'b0, {3'b000, bounce[7-k]}, 4'h0, 4'h0);
    for (int k = 0; k < 6; k++) add(1'b0, 4'h0, 4'h0, 4'h0);
    // Clean press/release on channel 1
    for (int i = 1; i <= 20; i++) add(1'b0, 4'h2, (i >= 7) ? 4'h2 : 4'h0, 4'h0);
    for (int j = 1; j <= 8; j++) add(1'b0, 4'h0, (j >= 7) ? 4'h0 : 4'h2, (j == 7) ? 4'h2 : 4'h0);
    // Simultaneous press/release on channels 0 and 3
    for (int i = 1; i <= 10; i++) add(1'b0, 4'h9, (i >= 7) ? 4'h9 : 4'h0, 4'h0);
    for (int j = 1; j <= 8; j++) add(1'b0, 4'h0, (j >= 7) ? 4'h0 : 4'h9, (j == 7) ? 4'h9 : 4'h0);
    // Reset mid-count discards the partial count
    for (int i = 0; i < 2; i++) add(1'b1, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) add(1'b0, 4'h1, 4'h0, 4'h0);
    add(1'b1, 4'h1, 4'h0, 4'h0);
    for (int i = 1; i <= 8; i++) add(1'b0, 4'h1, (i >= 7) ? 4'h1 : 4'h0, 4'h0);

    #2;
    check("reset_async_led", 0, led_d, 4'h0);
    check("reset_async_rel", 0, rel_d, 4'h0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      sw  = vecs[i].sw;
      step();
      check("vec_led", i, led_d, vecs[i].led);
      check("vec_rel", i, rel_d, vecs[i].rel);
    end

    // Toggle mode: three press/release pairs on channel 2
    rst = 1'b1;
    sw  = 4'h0;
    step();
    step();
    rst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 1; c <= 16; c++) begin
        logic [3:0] exp_led;
        sw = (c <= 8) ? 4'h4 : 4'h0;
        step();
        if (c >= 15) exp_led = ((p + 1) % 2 == 1) ? 4'h4 : 4'h0;
        else         exp_led = (p % 2 == 1) ? 4'h4 : 4'h0;
        check("toggle_led", p * 16 + c, led_t, exp_led);
        check("toggle_rel", p * 16 + c, rel_t, (c == 15) ? 4'h4 : 4'h0);
      end
    end

    // Press on all channels: direct LEDs follow, toggle LEDs hold
    sw = 4'hF;
    for (int i = 0; i < 10; i++) step();
    check("hold_direct_led", 0, led_d, 4'hF);
    check("hold_toggle_led", 0, led_t, 4'h4);

    // Asynchronous reset clears outputs before any clock edge
    rst = 1'b1;
    #2;
    check("async_direct_led", 1, led_d, 4'h0);
    check("async_toggle_led", 1, led_t, 4'h0);
    check("async_toggle_rel", 1, rel_t, 4'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
